// File: rtl/state_sequencer.sv
// state_sequencer: instruction-cycle sequencer for the Q2 core.
// Walks FETCH/DEREF/LOAD/EXEC/SHIFT/WB and drives the decoder-facing
// state bits s0..s3 (plus registered complements), the write strobe ws,
// and the front-panel run / halt / single-step handshake.
module state_sequencer #(
  parameter int SHIFT_LEN = 8
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [2:0] o,
  input  logic       deref,
  input  logic       mem_wait,
  input  logic       run,
  input  logic       step_req,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output logic       ns0,
  output logic       ns1,
  output logic       ns2,
  output logic       ns3,
  output logic       ws,
  output logic       halted,
  output logic       step_ack
);

  // Counter wide enough to hold SHIFT_LEN-1 (SHIFT_LEN is 2..16)
  localparam int CW = (SHIFT_LEN > 2) ? $clog2(SHIFT_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SHIFT_LEN - 1);

  typedef enum logic [2:0] {
    ST_HALT,
    ST_FETCH,
    ST_DEREF,
    ST_LOAD,
    ST_EXEC,
    ST_SHIFT,
    ST_WB
  } state_e;

  state_e        state_q, state_d;
  logic          ph_q, ph_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic          stepMode_q, stepMode_d;
  logic          stepPrev_q;
  logic [3:0]    sbits_q, sbits_d;
  logic [3:0]    nsbits_q;
  logic          ws_q, ws_d;
  logic          halted_q, halted_d;
  logic          stepAck_q, stepAck_d;

  logic          stepEdge;
  logic          aluOp;
  logic          endInstr;

  assign stepEdge = step_req & ~stepPrev_q;
  assign aluOp    = ~op_q[2] & (op_q[1:0] != 2'b00);

  // Next-state, instruction-end handling and registered output decode
  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    stepMode_d = stepMode_q;
    stepAck_d  = 1'b0;
    endInstr   = 1'b0;

    case (state_q)
      ST_HALT: begin
        if (run) begin
          state_d    = ST_FETCH;
          ph_d       = 1'b0;
          stepMode_d = 1'b0;
        end else if (stepEdge) begin
          state_d    = ST_FETCH;
          ph_d       = 1'b0;
          stepMode_d = 1'b1;
        end
      end

      ST_FETCH, ST_DEREF, ST_LOAD, ST_EXEC, ST_WB: begin
        if (!ph_q) begin
          if (!mem_wait) begin
            ph_d = 1'b1;
          end
        end else begin
          ph_d = 1'b0;
          case (state_q)
            ST_FETCH: begin
              op_d = o;
              if (deref) begin
                state_d = ST_DEREF;
              end else if (!o[2]) begin
                state_d = ST_LOAD;
              end else begin
                state_d = ST_EXEC;
              end
            end
            ST_DEREF: state_d = op_q[2] ? ST_EXEC : ST_LOAD;
            ST_LOAD:  state_d = ST_EXEC;
            ST_EXEC: begin
              if (aluOp) begin
                state_d = ST_SHIFT;
                cnt_d   = '0;
              end else begin
                endInstr = 1'b1;
              end
            end
            ST_WB:    endInstr = 1'b1;
            default:  state_d = ST_HALT;
          endcase
        end
      end

      ST_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_WB;
          ph_d    = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_HALT;
        ph_d    = 1'b0;
      end
    endcase

    if (endInstr) begin
      if (!stepMode_q && run) begin
        state_d = ST_FETCH;
      end else begin
        state_d    = ST_HALT;
        stepAck_d  = stepMode_q;
        stepMode_d = 1'b0;
      end
    end

    case (state_d)
      ST_FETCH: sbits_d = 4'b0000;
      ST_DEREF: sbits_d = 4'b0001;
      ST_LOAD:  sbits_d = 4'b0010;
      ST_EXEC:  sbits_d = 4'b0011;
      ST_SHIFT: sbits_d = 4'b0100;
      ST_WB:    sbits_d = 4'b1000;
      default:  sbits_d = 4'b0000;
    endcase

    ws_d     = ph_d & (state_d != ST_HALT) & (state_d != ST_SHIFT);
    halted_d = (state_d == ST_HALT);
  end

  // State register, instruction latches and step edge detector
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= ST_HALT;
      ph_q       <= 1'b0;
      cnt_q      <= '0;
      op_q       <= 3'b000;
      stepMode_q <= 1'b0;
      stepPrev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      stepMode_q <= stepMode_d;
      stepPrev_q <= step_req;
    end
  end

  // Output flops; true and complement bits load together so they never skew
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sbits_q   <= 4'b0000;
      nsbits_q  <= 4'b1111;
      ws_q      <= 1'b0;
      halted_q  <= 1'b1;
      stepAck_q <= 1'b0;
    end else begin
      sbits_q   <= sbits_d;
      nsbits_q  <= ~sbits_d;
      ws_q      <= ws_d;
      halted_q  <= halted_d;
      stepAck_q <= stepAck_d;
    end
  end

  assign s0       = sbits_q[0];
  assign s1       = sbits_q[1];
  assign s2       = sbits_q[2];
  assign s3       = sbits_q[3];
  assign ns0      = nsbits_q[0];
  assign ns1      = nsbits_q[1];
  assign ns2      = nsbits_q[2];
  assign ns3      = nsbits_q[3];
  assign ws       = ws_q;
  assign halted   = halted_q;
  assign step_ack = stepAck_q;

endmodule
